tlul_arb_wrr: RTL and testbench

Weighted round-robin request arbiter for the TL-UL M:1 socket. It sits between the host request FIFOs and the device request FIFO, in place of the plain PPC/tree arbiter. It grants one host per cycle, lets a host keep ownership for a configurable number of consecutive beats, and throttles each host by its count of outstanding (unanswered) requests. It also muxes the winning host's request payload onto the device side.

---
 rtl/tlul_arb_wrr.sv | 153 +++++++++++++++
 tb/tb_tlul_arb_wrr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tlul_arb_wrr.sv
// Weighted round-robin arbiter for the TL-UL M:1 request path, with per-host outstanding throttling.
// Define TLUL_ARB_OST_LIMIT_EN to build the outstanding counters, the MaxOst limit and ostd_err_o.
module tlul_arb_wrr #(
    parameter int unsigned      N       = 2,
    parameter int unsigned      DW      = 32,
    parameter logic [N*4-1:0]   Weights = {N{4'h1}},
    parameter int unsigned      MaxOst  = 4,
    parameter int unsigned      IW      = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    input  logic            ready_i,
    input  logic            rsp_done_i,
    input  logic [IW-1:0]   rsp_idx_i,
    output logic            ostd_err_o
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = IW + 1;

    logic [IW-1:0] cur;
    logic [CW-1:0] credit;
    logic [N-1:0]  elig;
    logic [IW-1:0] sel;
    logic [IW-1:0] scan_sel;
    logic [SW-1:0] cand;
    logic          found;
    logic          keep;
    logic          accept;
    logic [CW-1:0] wsel;
    logic [CW-1:0] credit_load;

`ifdef TLUL_ARB_OST_LIMIT_EN
    logic [CW-1:0] ost [N];
    logic          err;
    logic [N-1:0]  inc;
    logic [N-1:0]  dec;
    logic          idx_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_i[i] && (ost[i] < CW'(MaxOst));
        end
    end

    // Per-host accept/response strobes; an index matching no host is an error.
    always_comb begin
        inc    = '0;
        dec    = '0;
        idx_ok = 1'b0;
        for (int i = 0; i < N; i++) begin
            inc[i] = accept && (sel == IW'(i));
            dec[i] = rsp_done_i && (rsp_idx_i == IW'(i));
            if (rsp_idx_i == IW'(i)) begin
                idx_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                ost[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (inc[i] && !dec[i]) begin
                    ost[i] <= ost[i] + CW'(1);
                end else if (dec[i] && !inc[i]) begin
                    if (ost[i] == '0) begin
                        err <= 1'b1;
                    end else begin
                        ost[i] <= ost[i] - CW'(1);
                    end
                end
            end
            if (rsp_done_i && !idx_ok) begin
                err <= 1'b1;
            end
        end
    end

    assign ostd_err_o = err;
`else
    logic unused_rsp;

    assign elig       = req_i;
    assign unused_rsp = ^{rsp_done_i, rsp_idx_i};
    assign ostd_err_o = 1'b0;
`endif

    // Rotating scan starting after the last winner, with the winner itself checked last.
    always_comb begin
        scan_sel = cur;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, cur} + SW'(k);
            if (cand >= SW'(N)) begin
                cand = cand - SW'(N);
            end
            if (!found && elig[cand[IW-1:0]]) begin
                scan_sel = cand[IW-1:0];
                found    = 1'b1;
            end
        end
    end

    assign keep    = (credit != '0) && elig[cur];
    assign sel     = keep ? cur : scan_sel;
    assign valid_o = |elig;
    assign accept  = valid_o && ready_i;
    assign idx_o   = valid_o ? sel : '0;

    always_comb begin
        gnt_o  = '0;
        data_o = '0;
        wsel   = CW'(1);
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                gnt_o[i] = accept;
                wsel     = Weights[i*4 +: 4];
                if (valid_o) begin
                    data_o = data_i[i*DW +: DW];
                end
            end
        end
        credit_load = (wsel == '0) ? '0 : wsel - CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur    <= IW'(N - 1);
            credit <= '0;
        end else if (accept) begin
            if ((sel == cur) && (credit != '0)) begin
                credit <= credit - CW'(1);
            end else begin
                cur    <= sel;
                credit <= credit_load;
            end
        end
    end

endmodule

// File: tb/tb_tlul_arb_wrr.sv
// Directed bench for tlul_arb_wrr: N=3, DW=8, weights 3/2/1 for hosts 0/1/2, MaxOst=2.
module tb_tlul_arb_wrr;

`ifdef TLUL_ARB_OST_LIMIT_EN
    localparam bit OstEn = 1'b1;
`else
    localparam bit OstEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] data;
    logic [2:0]  gnt;
    logic [1:0]  idx;
    logic        valid;
    logic [7:0]  dout;
    logic        ready;
    logic        rsp_done;
    logic [1:0]  rsp_idx;
    logic        ostd_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] hdata [3] = '{8'hA0, 8'hB1, 8'hC2};
    int         wrr_order [10] = '{0, 0, 0, 1, 1, 2, 0, 0, 0, 1};
    int         prev;

    always #5 clk = ~clk;

    tlul_arb_wrr #(
        .N       (3),
        .DW      (8),
        .Weights (12'h123),
        .MaxOst  (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .data_i     (data),
        .gnt_o      (gnt),
        .idx_o      (idx),
        .valid_o    (valid),
        .data_o     (dout),
        .ready_i    (ready),
        .rsp_done_i (rsp_done),
        .rsp_idx_i  (rsp_idx),
        .ostd_err_o (ostd_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        req      = 3'b000;
        ready    = 1'b0;
        rsp_done = 1'b0;
        rsp_idx  = 2'd0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        data = {hdata[2], hdata[1], hdata[0]};
        apply_reset();

        // Idle after reset.
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_data", 32'(dout), 32'(0));
        check("rst_idx", 32'(idx), 32'(0));
        check("rst_err", 32'(ostd_err), 32'(0));
        next_cycle();

        // Back-pressure: selection visible, nothing granted, no state change.
        req   = 3'b110;
        ready = 1'b0;
        @(negedge clk);
        check("bp_valid", 32'(valid), 32'(1));
        check("bp_gnt", 32'(gnt), 32'(0));
        check("bp_idx", 32'(idx), 32'(1));
        check("bp_data", 32'(dout), 32'(8'hB1));
        next_cycle();
        next_cycle();
        req   = 3'b111;
        @(negedge clk);
        check("bp_idx_all", 32'(idx), 32'(0));
        check("bp_data_all", 32'(dout), 32'(8'hA0));
        next_cycle();

        // Weighted round robin, each grant answered on the following cycle.
        apply_reset();
        req   = 3'b111;
        ready = 1'b1;
        prev  = 0;
        for (int k = 0; k < 10; k++) begin
            rsp_done = (k > 0);
            rsp_idx  = 2'(prev);
            @(negedge clk);
            check($sformatf("wrr_gnt%0d", k), 32'(gnt), 32'(1) << wrr_order[k]);
            check($sformatf("wrr_data%0d", k), 32'(dout), 32'(hdata[wrr_order[k]]));
            next_cycle();
            prev = wrr_order[k];
        end
        req      = 3'b000;
        rsp_done = 1'b0;
        @(negedge clk);
        check("wrr_err", 32'(ostd_err), 32'(0));

        // Host 1 alone saturates at two outstanding, then resumes after one response.
        apply_reset();
        req   = 3'b010;
        ready = 1'b1;
        @(negedge clk);
        check("ost1_gnt0", 32'(gnt), 32'(3'b010));
        check("ost1_idx0", 32'(idx), 32'(1));
        next_cycle();
        @(negedge clk);
        check("ost1_gnt1", 32'(gnt), 32'(3'b010));
        next_cycle();
        rsp_done = 1'b1;
        rsp_idx  = 2'd1;
        @(negedge clk);
        check("ost1_gnt_full", 32'(gnt), OstEn ? 32'(0) : 32'(3'b010));
        check("ost1_valid_full", 32'(valid), OstEn ? 32'(0) : 32'(1));
        next_cycle();
        rsp_done = 1'b0;
        @(negedge clk);
        check("ost1_gnt_resume", 32'(gnt), 32'(3'b010));
        next_cycle();

        // Accept and response for host 0 in the same cycle leave its count unchanged.
        apply_reset();
        req   = 3'b001;
        ready = 1'b1;
        @(negedge clk);
        check("same_gnt0", 32'(gnt), 32'(3'b001));
        next_cycle();
        rsp_done = 1'b1;
        rsp_idx  = 2'd0;
        @(negedge clk);
        check("same_gnt1", 32'(gnt), 32'(3'b001));
        next_cycle();
        rsp_done = 1'b0;
        @(negedge clk);
        check("same_gnt2", 32'(gnt), 32'(3'b001));
        check("same_err", 32'(ostd_err), 32'(0));
        next_cycle();
        @(negedge clk);
        check("same_gnt3", 32'(gnt), OstEn ? 32'(0) : 32'(3'b001));
        next_cycle();

        // Response for an idle host sets the sticky error.
        apply_reset();
        rsp_done = 1'b1;
        rsp_idx  = 2'd2;
        @(negedge clk);
        check("err_same_cycle", 32'(ostd_err), 32'(0));
        next_cycle();
        rsp_done = 1'b0;
        @(negedge clk);
        check("err_idle_set", 32'(ostd_err), 32'(OstEn));
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("err_idle_hold", 32'(ostd_err), 32'(OstEn));
        next_cycle();
        apply_reset();
        @(negedge clk);
        check("err_cleared", 32'(ostd_err), 32'(0));
        next_cycle();

        // Response with an out-of-range index sets the error as well.
        rsp_done = 1'b1;
        rsp_idx  = 2'd3;
        next_cycle();
        rsp_done = 1'b0;
        @(negedge clk);
        check("err_range", 32'(ostd_err), 32'(OstEn));
        next_cycle();

        // Host 0 alone for ten cycles with no responses.
        apply_reset();
        req   = 3'b001;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("solo_gnt%0d", k), 32'(gnt),
                  (OstEn && k >= 2) ? 32'(0) : 32'(3'b001));
            next_cycle();
        end
        @(negedge clk);
        check("solo_err", 32'(ostd_err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
